// File: rtl/weighted_rr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Optional strict-priority classes are enabled with WEIGHTED_RR_ARB_PRIORITY_EN.
package weighted_rr_arb_pkg;

    localparam int MaxRequests = 32;
    localparam logic [5:0] GrantEncNone = '1;

    typedef enum logic {
        IDLE,
        OWN
    } arbState_e;

    // Bits 0..owner cleared, everything above set; owner 31 yields all zeros.
    function automatic logic [MaxRequests-1:0] nextMask(input logic [5:0] owner);
        logic [63:0] below;
        below = (64'd2 << owner) - 64'd1;
        return ~below[MaxRequests-1:0];
    endfunction

endpackage

// File: rtl/weighted_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Carries the prio vector only when WEIGHTED_RR_ARB_PRIORITY_EN is defined.
interface weighted_rr_arbiter_if #(
    parameter int NumRequests = 8,
    parameter int WeightBits  = 4
);
    localparam int EncW = $clog2(NumRequests) + 1;

    logic [NumRequests-1:0]            req;
    logic [NumRequests-1:0]            lock;
    logic [NumRequests*WeightBits-1:0] weight;
    logic                              ack;
`ifdef WEIGHTED_RR_ARB_PRIORITY_EN
    logic [NumRequests-1:0]            prio;
`endif
    logic [NumRequests-1:0]            grant;
    logic [EncW-1:0]                   grant_enc;
    logic                              grant_valid;
    logic [WeightBits-1:0]             credit;

    modport master (
        output req, lock, weight, ack,
        input  grant, grant_enc, grant_valid, credit
`ifdef WEIGHTED_RR_ARB_PRIORITY_EN
        , output prio
`endif
    );

    modport slave (
        input  req, lock, weight, ack,
        output grant, grant_enc, grant_valid, credit
`ifdef WEIGHTED_RR_ARB_PRIORITY_EN
        , input prio
`endif
    );

endinterface

// File: rtl/weighted_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: lowest set bit of req&mask,
// falling back to the lowest set bit of req when the masked set is empty.
module rr_pick
    import weighted_rr_arb_pkg::*;
#(
    parameter int NumRequests = 8
) (
    input  logic [NumRequests-1:0]         i_req,
    input  logic [NumRequests-1:0]         i_mask,
    output logic [NumRequests-1:0]         o_onehot,
    output logic [$clog2(NumRequests):0]   o_enc,
    output logic                           o_valid
);
    localparam int EncW = $clog2(NumRequests) + 1;

    logic [NumRequests-1:0] w_masked;
    logic [NumRequests-1:0] w_src;

    assign w_masked = i_req & i_mask;
    assign w_src    = (|w_masked) ? w_masked : i_req;
    assign o_valid  = |i_req;

    always_comb begin
        o_onehot = '0;
        o_enc    = GrantEncNone[EncW-1:0];
        for (int i = NumRequests - 1; i >= 0; i--) begin
            if (w_src[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_enc       = EncW'(i);
            end
        end
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Registered weighted round-robin arbiter with per-owner lock and credit.
// Define WEIGHTED_RR_ARB_PRIORITY_EN for a high/low class split with separate masks.
module weighted_rr_arbiter
    import weighted_rr_arb_pkg::*;
#(
    parameter int NumRequests = 8,
    parameter int WeightBits  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    weighted_rr_arbiter_if.slave bus
);
    localparam int EncW = $clog2(NumRequests) + 1;
    localparam logic [WeightBits-1:0] CreditOne = WeightBits'(1);

    arbState_e               r_state, w_stateNext;
    logic [NumRequests-1:0]  r_grant, w_grantNext;
    logic [EncW-1:0]         r_enc, w_encNext;
    logic [WeightBits-1:0]   r_credit, w_creditNext;

    logic                    w_ownerReq;
    logic                    w_ownerLock;
    logic [NumRequests-1:0]  w_candReq;
    logic [NumRequests-1:0]  w_pick;
    logic [EncW-1:0]         w_pickEnc;
    logic                    w_pickValid;
    logic [WeightBits-1:0]   w_pickWeight;
    logic [WeightBits-1:0]   w_loadCredit;
    logic [MaxRequests-1:0]  w_maskAfterPick;
    logic                    w_unusedMaskBits;
    logic                    w_doGrant;
    logic                    w_doIdle;

    assign w_ownerReq  = |(bus.req & r_grant);
    assign w_ownerLock = |(bus.lock & r_grant);
    // On release the outgoing owner is excluded so another requester can take over.
    assign w_candReq   = (r_state == OWN) ? (bus.req & ~r_grant) : bus.req;

`ifdef WEIGHTED_RR_ARB_PRIORITY_EN
    logic [NumRequests-1:0] r_maskHi, w_maskHiNext;
    logic [NumRequests-1:0] r_maskLo, w_maskLoNext;
    logic [NumRequests-1:0] w_hiPick, w_loPick;
    logic [EncW-1:0]        w_hiEnc, w_loEnc;
    logic                   w_hiValid, w_loValid;
    logic                   w_hiExists, w_useHi, w_useLo;

    rr_pick #(.NumRequests(NumRequests)) u_pickHi (
        .i_req    (w_candReq & bus.prio),
        .i_mask   (r_maskHi),
        .o_onehot (w_hiPick),
        .o_enc    (w_hiEnc),
        .o_valid  (w_hiValid)
    );

    rr_pick #(.NumRequests(NumRequests)) u_pickLo (
        .i_req    (w_candReq & ~bus.prio),
        .i_mask   (r_maskLo),
        .o_onehot (w_loPick),
        .o_enc    (w_loEnc),
        .o_valid  (w_loValid)
    );

    // The low class waits while any high-class request, including the owner's, is pending.
    assign w_hiExists  = |(bus.req & bus.prio);
    assign w_useHi     = w_hiValid;
    assign w_useLo     = !w_hiValid && !w_hiExists && w_loValid;
    assign w_pick      = w_useHi ? w_hiPick : (w_useLo ? w_loPick : '0);
    assign w_pickEnc   = w_useHi ? w_hiEnc : (w_useLo ? w_loEnc : GrantEncNone[EncW-1:0]);
    assign w_pickValid = w_useHi || w_useLo;
`else
    logic [NumRequests-1:0] r_mask, w_maskNext;

    rr_pick #(.NumRequests(NumRequests)) u_pick (
        .i_req    (w_candReq),
        .i_mask   (r_mask),
        .o_onehot (w_pick),
        .o_enc    (w_pickEnc),
        .o_valid  (w_pickValid)
    );
`endif

    always_comb begin
        w_pickWeight = '0;
        for (int i = 0; i < NumRequests; i++) begin
            if (w_pick[i]) begin
                w_pickWeight = bus.weight[i*WeightBits +: WeightBits];
            end
        end
    end

    assign w_loadCredit     = (w_pickWeight == '0) ? CreditOne : w_pickWeight;
    assign w_maskAfterPick  = nextMask(6'(w_pickEnc));
    assign w_unusedMaskBits = ^w_maskAfterPick;

    always_comb begin
        w_stateNext  = r_state;
        w_grantNext  = r_grant;
        w_encNext    = r_enc;
        w_creditNext = r_credit;
        w_doGrant    = 1'b0;
        w_doIdle     = 1'b0;
`ifdef WEIGHTED_RR_ARB_PRIORITY_EN
        w_maskHiNext = r_maskHi;
        w_maskLoNext = r_maskLo;
`else
        w_maskNext   = r_mask;
`endif
        if (ce) begin
            unique case (r_state)
                IDLE: begin
                    w_doGrant = w_pickValid;
                end
                OWN: begin
                    if (w_ownerLock) begin
                        if (bus.ack && (r_credit > CreditOne)) begin
                            w_creditNext = r_credit - CreditOne;
                        end
                    end else if (!w_ownerReq || (bus.ack && (r_credit == CreditOne))) begin
                        w_doGrant = w_pickValid;
                        w_doIdle  = !w_pickValid;
                    end else if (bus.ack) begin
                        w_creditNext = r_credit - CreditOne;
                    end
                end
                default: w_doIdle = 1'b1;
            endcase

            if (w_doGrant) begin
                w_stateNext  = OWN;
                w_grantNext  = w_pick;
                w_encNext    = w_pickEnc;
                w_creditNext = w_loadCredit;
`ifdef WEIGHTED_RR_ARB_PRIORITY_EN
                if (w_useHi) begin
                    w_maskHiNext = w_maskAfterPick[NumRequests-1:0];
                end else begin
                    w_maskLoNext = w_maskAfterPick[NumRequests-1:0];
                end
`else
                w_maskNext   = w_maskAfterPick[NumRequests-1:0];
`endif
            end else if (w_doIdle) begin
                w_stateNext  = IDLE;
                w_grantNext  = '0;
                w_encNext    = GrantEncNone[EncW-1:0];
                w_creditNext = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_enc    <= GrantEncNone[EncW-1:0];
            r_credit <= '0;
`ifdef WEIGHTED_RR_ARB_PRIORITY_EN
            r_maskHi <= '1;
            r_maskLo <= '1;
`else
            r_mask   <= '1;
`endif
        end else begin
            r_state  <= w_stateNext;
            r_grant  <= w_grantNext;
            r_enc    <= w_encNext;
            r_credit <= w_creditNext;
`ifdef WEIGHTED_RR_ARB_PRIORITY_EN
            r_maskHi <= w_maskHiNext;
            r_maskLo <= w_maskLoNext;
`else
            r_mask   <= w_maskNext;
`endif
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_enc   = r_enc;
    assign bus.grant_valid = |r_grant;
    assign bus.credit      = r_credit;

endmodule

// File: doc/weighted_rr_arbiter.md
Name: weighted_rr_arbiter

Overview:
- Registered, weighted round-robin arbiter for shared-bus and memory-port access, for N requesters.
- Each granted requester keeps the grant for a programmable number of acknowledged beats (its weight), or until it drops its request.
- A per-requester lock extends tenure for atomic sequences.
- Fairness pointer rotates past the last owner, so no requester starves.

Parameters:
- NumRequests, 8, number of requesters (2..32).
- WeightBits, 4, width of each per-requester weight field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- ce  in  1  clock enable; when low, all state holds and outputs are stable.
- req  in  NumRequests  request vector, level-sensitive.
- lock  in  NumRequests  lock bits; only the current owner's bit has effect.
- weight  in  NumRequests*WeightBits  beats per tenure; field i is bits [i*WeightBits +: WeightBits]; a value of 0 is treated as 1.
- ack  in  1  current owner consumed one beat this cycle.
- grant  out  NumRequests  registered one-hot grant.
- grant_enc  out  $clog2(NumRequests)+1  encoded owner; all-ones when no grant.
- grant_valid  out  1  high when grant is nonzero.
- credit  out  WeightBits  remaining beats in the current tenure, for debug.

Behaviour:
- Reset (rst=1 at a clk edge with ce ignored): grant=0, grant_enc=all-ones, grant_valid=0, credit=0, state=IDLE, pointer mask=all-ones (index 0 highest priority).
- States:
  - IDLE: no owner.
  - OWN: owner held.
- Pick function: masked request (req & mask) picks the lowest set index; if the masked request is zero, the unmasked req picks instead.
- mask after a grant to index k: bits 0..k cleared, bits k+1..N-1 set. If k=N-1 the mask becomes all zeros, so the unmasked pick wraps to index 0.
- IDLE, ce=1, req!=0: on the next edge, grant=onehot(pick), grant_enc=pick, credit=weight[pick] (0 is loaded as 1), state=OWN. Latency from req to grant is 1 cycle.
- IDLE, req=0: stay in IDLE; outputs remain in their reset values.
- OWN, ce=1, priority order of events:
  1. lock[owner]=1: grant held. ack decrements credit, but credit saturates at 1.
  2. req[owner]=0: release.
  3. ack=1 and credit==1: release.
  4. ack=1 and credit>1: credit decrements.
  5. Otherwise: hold.
- Release: on the same edge, the mask advances past the owner and the pick over the new mask is evaluated against the current req with the owner's bit excluded.
  - If that pick is nonzero, the grant goes directly to the new owner with no idle bubble, and credit loads from the new owner's weight.
  - Otherwise grant clears and state returns to IDLE.
- A sole requester whose credit expires while req is still high is re-granted one cycle later, via IDLE. This bubble is intentional so lock can be re-sampled.
- Changes to weight during a tenure do not affect the loaded credit.
- ack while in IDLE is ignored.
- ce=0 with ack=1: the ack is ignored, and the upstream must not count it.
- rst mid-tenure: grant drops on the same edge, with no completion of the tenure.

Optional Feature:
- Macro: WEIGHTED_RR_ARB_PRIORITY_EN.
- When defined:
  - Adds input prio [NumRequests].
  - Requesters with req&prio nonzero are arbitrated first, using their own rotating mask. Low-class requesters use a separate mask and are granted only when no high-class request exists.
  - A high-class request never preempts a current owner; it wins at the next release.
  - Lock semantics are unchanged.
- When undefined: no prio port, a single mask, behaviour exactly as above.

Decomposition:
- Package weighted_rr_arb_pkg:
  - function computing the next mask from an owner index.
  - constant for the none-encoding (all-ones).
  - typedef for the state enum {IDLE, OWN}.
- Sub-module rr_pick: purely combinational. Inputs req and mask; outputs a one-hot pick and its encoded index, using the masked-then-unmasked selection.
  - Instantiated once without WEIGHTED_RR_ARB_PRIORITY_EN, twice with it (one instance per class).

Test Plan:
- N=8, all weights=2, req=0xFF, ack held high: grant sequence is 0,0,1,1,2,2,…,7,7,0 with no bubbles; credit toggles 2,1.
- req=0x05, weight[0]=3, weight[2]=0, ack every cycle: owner 0 holds for 3 beats, owner 2 for 1 beat, repeating.
- Owner 3 with lock[3]=1, credit=1, 10 acks: grant stays 0x08 and credit stays 1. Drop lock with ack high: release on that edge; grant passes to the next requester.
- Owner 5 drops req mid-tenure (credit=4) while req[6]=1: the next edge grants 6 with credit=weight[6]. With no other requester: IDLE, grant_enc=all-ones.
- ce=0 for 5 cycles with ack=1 during a tenure: credit and grant are unchanged. rst pulse mid-tenure: grant=0 and grant_valid=0 the following cycle.
- WEIGHTED_RR_ARB_PRIORITY_EN with prio=0x80, req=0xFF, weights=1: owner 7 recurs on every release; lower requesters are served only when req[7]=0.
